ifu: RTL

Instruction fetch unit, sitting directly upstream of the icache. It owns the fetch PC and issues one fetch request at a time on the icache's AXI-style read channels (AR/R). It buffers each returned 32-bit instruction with its PC in a one-entry skid register for the decode stage. It also handles redirects from the back end (jump/branch/trap), discarding stale in-flight responses.

---
 rtl/ifu.sv | 115 +++++++++++
 1 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one AR/R fetch at a time to the
// icache and holds the returned word in a one-entry buffer for decode, honouring redirects.
module ifu #(
  parameter logic [63:0] RST_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag,
  input  logic [63:0] jump_addr,
  input  logic        ifu_arready,
  output logic        ifu_arvalid,
  output logic [63:0] ifu_araddr,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  input  logic [1:0]  ifu_rresp,
  input  logic [31:0] ifu_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_fault
);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] fetch_pc;
  logic [63:0] redir_pc;
  logic        flush_pending;
  logic [63:0] jump_target;
  logic        r_hs;
  logic        flushing;
  logic        buf_write;

  assign jump_target = jump_addr & ~64'h3;
  assign ifu_araddr  = fetch_pc;
  assign r_hs        = ifu_rready && ifu_rvalid;
  assign flushing    = flush_pending || jump_flag;
  assign buf_write   = r_hs && !flushing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    ifu_arvalid = 1'b0;
    ifu_rready  = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = AR;
      end
      AR: begin
        ifu_arvalid = 1'b1;
        if (ifu_arready) state_next = R;
      end
      R: begin
        ifu_rready = !inst_valid || inst_ready;
        if (ifu_rvalid && ifu_rready) state_next = AR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A redirect that cannot act on an R beat this cycle is parked in redir_pc, so the
  // address presented on AR never changes before its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc      <= RST_PC;
      redir_pc      <= 64'd0;
      flush_pending <= 1'b0;
    end else if (r_hs) begin
      flush_pending <= 1'b0;
      if (flushing) begin
        fetch_pc <= jump_flag ? jump_target : redir_pc;
      end else begin
        fetch_pc <= fetch_pc + 64'd4;
      end
    end else if (jump_flag) begin
      redir_pc      <= jump_target;
      flush_pending <= 1'b1;
    end
  end

  // A redirect voids whatever sits in the buffer, even if decode is taking it this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 64'd0;
      inst_fault <= 1'b0;
    end else if (jump_flag) begin
      inst_valid <= 1'b0;
    end else if (buf_write) begin
      inst_valid <= 1'b1;
      inst       <= ifu_rdata;
      inst_pc    <= fetch_pc;
      inst_fault <= |ifu_rresp;
    end else if (inst_ready) begin
      inst_valid <= 1'b0;
    end
  end

endmodule
